// File: rtl/decodificador_instrucao.sv
// decodificador_instrucao
// This block holds the instruction register (RI), the N/Z flag registers, the
// RUN/HALT latch and the fetched-instruction counter for the 8-bit
// accumulator processor.
// All outputs are decoded from registers only, so no input reaches an output
// within the same cycle.
module decodificador_instrucao #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeRI,
    input  logic [DATA_W-1:0] dataRDM,
    input  logic              writeN,
    input  logic              writeZ,
    input  logic [DATA_W-1:0] resultULA,
    input  logic              resume,
    output logic              sNOP,
    output logic              sSTA,
    output logic              sLDA,
    output logic              sADD,
    output logic              sSUB,
    output logic              sAND,
    output logic              sOR,
    output logic              sNOT,
    output logic              sJ,
    output logic              sJN,
    output logic              sJZ,
    output logic              sIN,
    output logic              sOUT,
    output logic              sSHR,
    output logic              sSHL,
    output logic              sHLT,
    output logic              sDIR,
    output logic              sIND,
    output logic              sIM,
    output logic              sSOP,
    output logic              sN,
    output logic              sZ,
    output logic              illegal,
    output logic              run,
    output logic              halted,
    output logic [CNT_W-1:0]  instrCount
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_STA = 4'h1, OP_LDA = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_NOT = 4'h7,
        OP_J   = 4'h8, OP_JN  = 4'h9, OP_JZ  = 4'hA, OP_IN  = 4'hB,
        OP_OUT = 4'hC, OP_SHR = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        MD_DIR = 2'b00,
        MD_IND = 2'b01,
        MD_IM  = 2'b10,
        MD_RSV = 2'b11
    } mode_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_ri;
    logic              r_n;
    logic              r_z;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_running;
    logic              w_load;
    logic              w_resume;
    opcode_t           w_opcode;
    mode_t             w_mode;
    logic              w_no_operand;
    logic              w_reserved;
    logic              w_unused_ri_bits;

    // RI[3:2] carry no meaning in the instruction format.
    assign w_unused_ri_bits = ^r_ri[3:2];

    assign w_running = (r_state == ST_RUN);
    assign w_load    = w_running && writeRI;
    assign w_resume  = !w_running && resume;

    // State register: RUN/HALT latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: halt on an accepted HLT load, leave only on resume.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (writeRI && (dataRDM[7:4] == OP_HLT)) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // State outputs.
    always_comb begin
        run    = 1'b0;
        halted = 1'b0;
        case (r_state)
            ST_RUN:  run    = 1'b1;
            ST_HALT: halted = 1'b1;
            default: run    = 1'b1;
        endcase
    end

    // Instruction register: resume clears it so the HLT is not re-decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ri <= '0;
        end else if (w_resume) begin
            r_ri <= '0;
        end else if (w_load) begin
            r_ri <= dataRDM[7:0];
        end
    end

    // Flag registers: independent enables, frozen while halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= 1'b0;
            r_z <= 1'b1;
        end else if (w_running) begin
            if (writeN) begin
                r_n <= resultULA[DATA_W-1];
            end
            if (writeZ) begin
                r_z <= (resultULA == '0);
            end
        end
    end

    // Fetched-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_opcode = opcode_t'(r_ri[7:4]);
    assign w_mode   = mode_t'(r_ri[1:0]);

    // Operand-less opcodes take no addressing mode.
    always_comb begin
        w_no_operand = 1'b0;
        case (w_opcode)
            OP_NOP, OP_NOT, OP_SHR, OP_SHL, OP_HLT: w_no_operand = 1'b1;
            default:                                w_no_operand = 1'b0;
        endcase
    end

    assign w_reserved = !w_no_operand && (w_mode == MD_RSV);

    // Opcode strobes: a reserved encoding decodes as NOP to keep one-hot.
    always_comb begin
        sNOP = 1'b0; sSTA = 1'b0; sLDA = 1'b0; sADD = 1'b0;
        sSUB = 1'b0; sAND = 1'b0; sOR  = 1'b0; sNOT = 1'b0;
        sJ   = 1'b0; sJN  = 1'b0; sJZ  = 1'b0; sIN  = 1'b0;
        sOUT = 1'b0; sSHR = 1'b0; sSHL = 1'b0; sHLT = 1'b0;
        if (w_reserved) begin
            sNOP = 1'b1;
        end else begin
            case (w_opcode)
                OP_NOP: sNOP = 1'b1;
                OP_STA: sSTA = 1'b1;
                OP_LDA: sLDA = 1'b1;
                OP_ADD: sADD = 1'b1;
                OP_SUB: sSUB = 1'b1;
                OP_AND: sAND = 1'b1;
                OP_OR:  sOR  = 1'b1;
                OP_NOT: sNOT = 1'b1;
                OP_J:   sJ   = 1'b1;
                OP_JN:  sJN  = 1'b1;
                OP_JZ:  sJZ  = 1'b1;
                OP_IN:  sIN  = 1'b1;
                OP_OUT: sOUT = 1'b1;
                OP_SHR: sSHR = 1'b1;
                OP_SHL: sSHL = 1'b1;
                OP_HLT: sHLT = 1'b1;
                default: sNOP = 1'b1;
            endcase
        end
    end

    // Mode strobes: operand-less and reserved encodings both report SOP.
    always_comb begin
        sDIR = 1'b0;
        sIND = 1'b0;
        sIM  = 1'b0;
        sSOP = 1'b0;
        if (w_no_operand || w_reserved) begin
            sSOP = 1'b1;
        end else begin
            case (w_mode)
                MD_DIR:  sDIR = 1'b1;
                MD_IND:  sIND = 1'b1;
                MD_IM:   sIM  = 1'b1;
                default: sSOP = 1'b1;
            endcase
        end
    end

    assign illegal    = w_reserved;
    assign sN         = r_n;
    assign sZ         = r_z;
    assign instrCount = r_cnt;

endmodule

// File: tb/tb_decodificador_instrucao.sv
module tb_decodificador_instrucao;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic writeRI = 1'b0;
    logic [DATA_W-1:0] dataRDM = '0;
    logic writeN = 1'b0;
    logic writeZ = 1'b0;
    logic [DATA_W-1:0] resultULA = '0;
    logic resume = 1'b0;
    logic sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT;
    logic sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT;
    logic sDIR, sIND, sIM, sSOP, sN, sZ, illegal, run, halted;
    logic [CNT_W-1:0] instrCount;

    int tests = 0;
    int fails = 0;

    decodificador_instrucao #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .writeRI(writeRI), .dataRDM(dataRDM),
        .writeN(writeN), .writeZ(writeZ), .resultULA(resultULA), .resume(resume),
        .sNOP(sNOP), .sSTA(sSTA), .sLDA(sLDA), .sADD(sADD), .sSUB(sSUB),
        .sAND(sAND), .sOR(sOR), .sNOT(sNOT), .sJ(sJ), .sJN(sJN), .sJZ(sJZ),
        .sIN(sIN), .sOUT(sOUT), .sSHR(sSHR), .sSHL(sSHL), .sHLT(sHLT),
        .sDIR(sDIR), .sIND(sIND), .sIM(sIM), .sSOP(sSOP), .sN(sN), .sZ(sZ),
        .illegal(illegal), .run(run), .halted(halted), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state of the machine.
    int m_ri   = 0;
    int m_n    = 0;
    int m_z    = 1;
    int m_halt = 0;
    int m_cnt  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ri = 0; m_n = 0; m_z = 1; m_halt = 0; m_cnt = 0;
        end else if (m_halt != 0) begin
            if (resume) begin
                m_halt = 0;
                m_ri = 0;
            end
        end else begin
            if (writeN) m_n = int'(resultULA[DATA_W-1]);
            if (writeZ) m_z = (resultULA == 0) ? 1 : 0;
            if (writeRI) begin
                m_ri = int'(dataRDM);
                m_cnt = (m_cnt + 1) % 65536;
                if (m_ri / 16 == 15) m_halt = 1;
            end
        end
    end

    // Output vector layout: {opcode one-hot[15:0], mode {SOP,IM,IND,DIR},
    // N, Z, illegal, run, halted, count[15:0]}.
    function automatic logic [40:0] model_vec();
        int opc, md;
        bit needs_operand;
        logic [15:0] op;
        logic [3:0] mode;
        logic ill;
        opc = m_ri / 16;
        md = m_ri % 4;
        needs_operand = !(opc inside {0, 7, 13, 14, 15});
        ill = needs_operand && md == 3;
        op = '0;
        mode = '0;
        if (ill) begin
            op[0] = 1'b1;
            mode[3] = 1'b1;
        end else begin
            op[opc] = 1'b1;
            if (needs_operand) mode[md] = 1'b1;
            else mode[3] = 1'b1;
        end
        return {op, mode, 1'(m_n), 1'(m_z), ill, 1'(m_halt == 0), 1'(m_halt), 16'(m_cnt)};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {sHLT, sSHL, sSHR, sOUT, sIN, sJZ, sJN, sJ, sNOT, sOR, sAND, sSUB,
                sADD, sLDA, sSTA, sNOP, sSOP, sIM, sIND, sDIR,
                sN, sZ, illegal, run, halted, instrCount};
    endfunction

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        logic [40:0] a, e;
        a = dut_vec();
        e = model_vec();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, a, e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs drop right after the sampling edge.
    task automatic cyc(input logic wri, input logic [7:0] d, input logic wn,
                       input logic wz, input logic [7:0] res, input logic rsm);
        @(negedge clk);
        writeRI = wri; dataRDM = d; writeN = wn; writeZ = wz;
        resultULA = res; resume = rsm;
        @(posedge clk);
        #1;
        writeRI = 1'b0; writeN = 1'b0; writeZ = 1'b0; resume = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        #12 rst = 1'b0;

        // Asynchronous reset with RI holding 0x32.
        load(8'h32);
        chk("pre_rst_sADD", 32'(sADD), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_sNOP", 32'(sNOP), 1);
        chk("rst_sSOP", 32'(sSOP), 1);
        chk("rst_flags", {30'b0, sN, sZ}, 32'h1);
        chk("rst_run", {30'b0, run, halted}, 32'h2);
        chk("rst_cnt", 32'(instrCount), 0);
        chk("rst_ill", 32'(illegal), 0);
        #1 rst = 1'b0;

        load(8'h21);
        chk("ld21", {30'b0, sLDA, sIND}, 32'h3);
        load(8'h36);
        chk("ld36", {30'b0, sADD, sIM}, 32'h3);
        load(8'h40);
        chk("ld40", {30'b0, sSUB, sDIR}, 32'h3);
        chk("cnt3", 32'(instrCount), 3);
        load(8'h73);
        chk("ld73", {29'b0, sNOT, sSOP, illegal}, 32'h6);
        load(8'h13);
        chk("ld13", {28'b0, sNOP, sSOP, illegal, sSTA}, 32'hE);

        cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0);
        chk("flag80", {30'b0, sN, sZ}, 32'h2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("flagZ", {30'b0, sN, sZ}, 32'h3);

        load(8'hF0);
        chk("hlt", {29'b0, sHLT, halted, run}, 32'h6);
        chk("cnt6", 32'(instrCount), 6);
        cyc(1'b1, 8'h20, 1'b1, 1'b1, 8'h55, 1'b0);
        chk("halt_hold", {28'b0, sHLT, sLDA, sN, sZ}, 32'hB);
        chk("halt_cnt", 32'(instrCount), 6);
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("resume", {29'b0, run, sNOP, sLDA}, 32'h6);
        chk("resume_cnt", 32'(instrCount), 6);
        load(8'hF1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("resume_only", {30'b0, run, sNOP}, 32'h3);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("resume_in_run", 32'(run), 1);

        // Random phase, with occasional mid-cycle asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            cyc($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                $urandom_range(0, 4) == 0);
        end

        // Counter wrap: 0xFFFF loads of non-HLT bytes, then one more.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        writeRI = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            d = 8'($urandom_range(0, 239));
            dataRDM = d;
            @(negedge clk);
        end
        writeRI = 1'b0;
        chk("cnt_ffff", 32'(instrCount), 32'hFFFF);
        load(8'h00);
        chk("cnt_wrap", 32'(instrCount), 0);
        chk("wrap_nop", 32'(sNOP), 1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decodificador_instrucao.md
# decodificador_instrucao

Instruction register, decoder, flag register and halt latch for the 8-bit accumulator processor; sits directly upstream of the control unit. It captures the instruction byte from RDM on `writeRI` and presents the registered one-hot opcode strobes, addressing-mode strobes and N/Z flags that the control unit consumes. It also freezes the machine on HLT until `resume`, and counts fetched instructions.

## Interface
- `DATA_W`, 8: width of RDM and ULA data paths; instruction format is fixed to 8 bits.
- `CNT_W`, 16: width of the instruction counter.

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `writeRI`  in  1  load RI from `dataRDM` at this edge
- `dataRDM`  in  DATA_W  instruction byte from RDM
- `writeN`  in  1  update N from `resultULA`
- `writeZ`  in  1  update Z from `resultULA`
- `resultULA`  in  DATA_W  ULA output
- `resume`  in  1  single-cycle pulse, leave HALT
- `sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT, sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT`  out  1 each  one-hot opcode strobes
- `sDIR, sIND, sIM, sSOP`  out  1 each  one-hot mode strobes
- `sN, sZ`  out  1 each  flag registers
- `illegal`  out  1  RI holds a reserved encoding
- `run`  out  1  machine enabled (inverse of halted)
- `halted`  out  1  HALT state
- `instrCount`  out  CNT_W  instructions fetched since reset

## Operation
- Encoding: RI[7:4] opcode: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 J, 9 JN, A JZ, B IN, C OUT, D SHR, E SHL, F HLT. RI[3:2] ignored. RI[1:0] mode: 00 DIR, 01 IND, 10 IM, 11 reserved.
- NOP, NOT, SHR, SHL, HLT: `sSOP`=1, other mode strobes 0, RI[1:0] ignored.
- All other opcodes: mode strobe from RI[1:0]; `sSOP`=0.
- Reserved (operand opcode with mode 11): decode forced to `sNOP`=1, `sSOP`=1, `illegal`=1. Exactly one opcode strobe and exactly one mode strobe high at all times.
- Strobes are combinational from the RI register only (never from `dataRDM`).
- Flags: on `writeN`, N <= resultULA[DATA_W-1]. On `writeZ`, Z <= (resultULA == 0). Independent enables.
- State machine RUN/HALT:
  - RUN -> HALT at the edge where `writeRI`=1 and `dataRDM[7:4]`=F.
  - HALT -> RUN at the edge where `resume`=1. At that same edge RI <= 0x00, so the machine does not re-halt.
  - `resume` in RUN is ignored.
- In HALT, `writeRI`, `writeN` and `writeZ` are ignored; RI, flags and counter hold.
- `instrCount` increments on every accepted `writeRI`, including the HLT load. Wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous, any time, including mid-instruction or in HALT): RI=0x00 (`sNOP`=1, `sSOP`=1, others 0), N=0, Z=1, `illegal`=0, state RUN (`run`=1, `halted`=0), `instrCount`=0.

## Timing
- RI, flags, state and counter are registers. Decoded strobes are valid from the cycle after the `writeRI` edge, i.e. in the control unit's t3.
- `halted`/`run` change one edge after the triggering `writeRI` or `resume`, so they change together with the `sHLT` strobe.
- Flag latency: `sN`/`sZ` update one edge after `writeN`/`writeZ` is sampled. A conditional jump decoded in the following t3 sees the new value.
- Simultaneous `writeRI` and `resume` in HALT: resume wins. RI <= 0x00, no load, no count.
- Simultaneous `writeN` and `writeZ`: both update from the same `resultULA`.
- No combinational path from any input to any output.

## Test plan
- Reset with RI previously 0x32: assert `rst` asynchronously mid-cycle -> immediately `sNOP`=1, `sSOP`=1, `sZ`=1, `sN`=0, `run`=1, `instrCount`=0.
- Load 0x21, 0x36, 0x40 -> one cycle after each: (`sLDA`, `sIND`), (`sADD`, `sIM`), (`sSUB`, `sDIR`). `instrCount`=3. Load 0x73 -> `sNOT`, `sSOP`, `illegal`=0.
- Load 0x13 -> `sNOP`=1, `sSOP`=1, `illegal`=1, `sSTA`=0.
- `writeN`+`writeZ` with resultULA=0x80 -> `sN`=1, `sZ`=0. Then `writeZ` only with 0x00 -> `sN`=1, `sZ`=1.
- Load 0xF0 -> `sHLT`, `halted`=1, `run`=0. Then `writeRI` 0x20 and `writeN` with 0x80 -> RI, `sN` and count unchanged. `resume` together with `writeRI` -> `run`=1, `sNOP`=1, count unchanged.
- Preload count to 0xFFFF, load 0x00 -> `instrCount`=0x0000.
